// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer link transmitter.
// Setting SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package serializer_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

`ifdef SERIALIZER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int FRAME_BITS = DEFAULT_DATA_WIDTH + PARITY_BITS;

  // The caller zero-extends the word, so leading zeros leave the parity unchanged.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serializer.sv
// MSB-first parallel-to-serial transmitter with a per-bit valid/ready handshake.
// Setting SERIALIZER_PARITY_EN appends an even-parity bit after the LSB.
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock_100k,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load_in,
  input  logic                  ready_in,
  output logic                  serial_out,
  output logic                  write_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int FRAME_LEN = DATA_WIDTH + PARITY_BITS;
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  ser_state_t           state, state_next;
  logic [FRAME_LEN-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 done, done_next;
  logic [FRAME_LEN-1:0] load_word;

`ifdef SERIALIZER_PARITY_EN
  logic [63:0] parity_src;
  assign parity_src = 64'(data_in);
  assign load_word  = {data_in, even_parity(parity_src)};
`else
  assign load_word  = data_in;
`endif

  always_ff @(posedge clock_100k) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // Shifting in zeros leaves the register cleared once the last bit has gone out.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (load_in) begin
          state_next = SHIFT;
          shreg_next = load_word;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (ready_in) begin
          shreg_next = shreg << 1;
          cnt_next   = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_out   = (state == SHIFT);
  assign write_out  = (state == SHIFT);
  assign serial_out = (state == SHIFT) && shreg[FRAME_LEN-1];
  assign done_out   = done;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: table-driven frames plus reset corner cases,
// with a bit scoreboard fed at load time and drained on every accepted transfer.
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int TB_FRAME = 9;
`else
  localparam int TB_FRAME = 8;
`endif
  localparam int BUDGET = 60;

  logic       clock_100k;
  logic       reset;
  logic [7:0] data_in;
  logic       load_in;
  logic       ready_in;
  logic       serial_out;
  logic       write_out;
  logic       busy_out;
  logic       done_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         stall_at;
    int         stall_len;
    int         busy_at;
    logic [7:0] busy_data;
    bit         chain;
    logic [7:0] chain_data;
  } vec_t;

  vec_t vecs[7];

  serializer #(.DATA_WIDTH(8)) dut (
    .clock_100k (clock_100k),
    .reset      (reset),
    .data_in    (data_in),
    .load_in    (load_in),
    .ready_in   (ready_in),
    .serial_out (serial_out),
    .write_out  (write_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  initial clock_100k = 1'b0;
  always #5 clock_100k = ~clock_100k;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock_100k);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic push_expected(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // Drives a load during an idle cycle; returns in the first cycle of the frame.
  task automatic applyStimulus(input logic [7:0] d);
    data_in  = d;
    load_in  = 1'b1;
    ready_in = 1'b1;
    push_expected(d);
    tick();
    load_in = 1'b0;
  endtask

  task automatic runFrame(input int stall_at, input int stall_len, input int busy_at,
                          input logic [7:0] busy_data, input bit chain,
                          input logic [7:0] chain_data);
    int cycle;
    int bit_idx;
    int stall_left;
    cycle      = 1;
    bit_idx    = 0;
    stall_left = stall_len;
    while (!done_out && cycle <= BUDGET) begin
      checkOutput("write_out_in_frame", write_out, 1);
      checkOutput("busy_out_in_frame", busy_out, 1);
      if (cycle == busy_at) begin
        load_in = 1'b1;
        data_in = busy_data;
      end else begin
        load_in = 1'b0;
      end
      if (bit_idx == stall_at && stall_left > 0) begin
        ready_in = 1'b0;
        stall_left--;
        if (exp_q.size() > 0) checkOutput("stall_hold", serial_out, exp_q[0]);
      end else begin
        ready_in = 1'b1;
        if (exp_q.size() > 0) checkOutput("serial_bit", serial_out, exp_q.pop_front());
        else checkOutput("extra_bit", 1, 0);
        bit_idx++;
      end
      tick();
      cycle++;
    end
    if (!done_out) begin
      checkOutput("done_timeout", 0, 1);
      return;
    end
    checkOutput("done_latency", cycle, TB_FRAME + 1 + stall_len);
    checkOutput("serial_after_done", serial_out, 0);
    checkOutput("write_after_done", write_out, 0);
    checkOutput("busy_after_done", busy_out, 0);
    checkOutput("bits_left", exp_q.size(), 0);
    ready_in = 1'b1;
    if (chain) begin
      data_in = chain_data;
      load_in = 1'b1;
      push_expected(chain_data);
    end else begin
      load_in = 1'b0;
    end
    tick();
    load_in = 1'b0;
    checkOutput("done_pulse_width", done_out, 0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stall_at: -1, stall_len: 0, busy_at: -1, busy_data: 8'h00, chain: 1'b0, chain_data: 8'h00};
    vecs[1] = '{data: 8'h3C, stall_at: 2,  stall_len: 3, busy_at: -1, busy_data: 8'h00, chain: 1'b0, chain_data: 8'h00};
    vecs[2] = '{data: 8'h0F, stall_at: -1, stall_len: 0, busy_at: 3,  busy_data: 8'hF0, chain: 1'b0, chain_data: 8'h00};
    vecs[3] = '{data: 8'h11, stall_at: -1, stall_len: 0, busy_at: -1, busy_data: 8'h00, chain: 1'b1, chain_data: 8'h22};
    vecs[4] = '{data: 8'h07, stall_at: -1, stall_len: 0, busy_at: -1, busy_data: 8'h00, chain: 1'b0, chain_data: 8'h00};
    vecs[5] = '{data: 8'h03, stall_at: 7,  stall_len: 2, busy_at: -1, busy_data: 8'h00, chain: 1'b0, chain_data: 8'h00};
    vecs[6] = '{data: 8'hC6, stall_at: 0,  stall_len: 1, busy_at: 5,  busy_data: 8'hFF, chain: 1'b0, chain_data: 8'h00};

    reset    = 1'b1;
    load_in  = 1'b0;
    ready_in = 1'b1;
    data_in  = 8'h00;
    tick();
    tick();
    checkOutput("reset_serial", serial_out, 0);
    checkOutput("reset_write", write_out, 0);
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_done", done_out, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data);
      runFrame(vecs[i].stall_at, vecs[i].stall_len, vecs[i].busy_at,
               vecs[i].busy_data, vecs[i].chain, vecs[i].chain_data);
      if (vecs[i].chain) runFrame(-1, 0, -1, 8'h00, 1'b0, 8'h00);
      tick();
      checkOutput("idle_busy", busy_out, 0);
    end

    // Reset in the middle of a 0xFF frame discards it.
    data_in  = 8'hFF;
    load_in  = 1'b1;
    ready_in = 1'b1;
    tick();
    load_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midframe_serial", serial_out, 1);
    checkOutput("midframe_busy", busy_out, 1);
    reset   = 1'b1;
    load_in = 1'b1;
    tick();
    checkOutput("midreset_serial", serial_out, 0);
    checkOutput("midreset_write", write_out, 0);
    checkOutput("midreset_busy", busy_out, 0);
    checkOutput("midreset_done", done_out, 0);
    reset   = 1'b0;
    load_in = 1'b0;
    tick();
    checkOutput("post_reset_idle", busy_out, 0);
    applyStimulus(8'h81);
    runFrame(-1, 0, -1, 8'h00, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serializer.md
# serializer

Parallel-to-serial transmitter that drives the serial link consumed by the deserializer. It accepts one byte at a time from a producer (testbench, or a queue read port with `deq_in`/`data_out`) and shifts it out MSB-first, one bit per accepted transfer. Each bit uses a valid/ready handshake, so the deserializer can stall the link while its queue is full. It runs in the deserializer's clock domain, with no clock crossing.

## Interface
- `DATA_WIDTH`, default 8: width of the parallel word. The shift counter is `$clog2(DATA_WIDTH+1)+1` bits wide.
- `clock_100k`  in  1: single system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clock_100k`.
- `data_in`  in  DATA_WIDTH: parallel word; sampled only when a load is accepted.
- `load_in`  in  1: load request; accepted on a rising edge where `busy_out`=0.
- `ready_in`  in  1: deserializer can take a bit this cycle.
- `serial_out`  out  1: current bit on the link.
- `write_out`  out  1: `serial_out` is valid (bit strobe).
- `busy_out`  out  1: a frame is in progress; further loads are ignored.
- `done_out`  out  1: one-cycle pulse when the last bit of a frame has transferred.

## Operation
- **States (FSM):**
  - `IDLE`: `busy_out`=0, `write_out`=0.
  - `SHIFT`: `busy_out`=1, `write_out`=1.
- **IDLE → SHIFT:** on a rising edge with `load_in`=1.
  - `data_in` is latched into the shift register.
  - The bit counter is cleared.
- **Bit transfer:**
  - A transfer occurs on a rising edge where `write_out`=1 and `ready_in`=1.
  - On each transfer the shift register shifts left, so `serial_out` is always `shreg[MSB]`.
  - The counter then increments.
- **Stall:**
  - If `ready_in`=0, `serial_out` and `write_out` hold their values.
  - The counter does not move.
  - A stall may last any number of cycles.
- **SHIFT → IDLE:** on the transfer of the final frame bit (FRAME_BITS transfers in total).
  - `done_out`=1 for exactly the following cycle.
  - `serial_out` returns to 0.
- **Busy load:** `load_in`=1 while `busy_out`=1 is ignored; no data is latched and there is no error flag.
- **Back-to-back frames:** a load in the same cycle that `done_out`=1 is accepted, because `busy_out` is already 0.
- **Output decode:** all outputs are registered or decoded from registered state only. There is no combinational path from `ready_in` to any output.
- **Reset (including mid-frame):**
  - All outputs go to 0 on the next edge: `serial_out`, `write_out`, `busy_out`, `done_out`.
  - State returns to `IDLE`; shift register and counter are cleared.
  - Any partial frame is discarded.

## Timing
- Load accepted at edge N:
  - `write_out`=1 and first bit (MSB) on `serial_out` during cycle N+1.
- `ready_in` held at 1:
  - The k-th bit (k=0..FRAME_BITS-1) is on the link during cycle N+1+k.
  - `done_out`=1 during cycle N+1+FRAME_BITS.
- Each stall cycle delays all later bits and `done_out` by exactly one cycle.
- Minimum frame period is FRAME_BITS+1 cycles: 9 without parity, 10 with parity.
- Reset has priority over `load_in` and over any transfer in the same cycle.

## Configuration
- Macro: `SERIALIZER_PARITY_EN`.
- **Defined:**
  - FRAME_BITS = DATA_WIDTH+1.
  - An even-parity bit (XOR of `data_in`, computed at load) is appended after the LSB.
  - The shift register is DATA_WIDTH+1 wide.
- **Undefined:**
  - FRAME_BITS = DATA_WIDTH.
  - No parity logic exists.

## Structure
- **Shared package `serializer_pkg`** holds:
  - the state typedef `ser_state_t {IDLE, SHIFT}`;
  - the `FRAME_BITS` constant, derived under the macro;
  - the function `even_parity()`.
- **Sub-modules:** none; the FSM, shift register and counter are a single module.

## Test plan
- **Basic frame:** reset, then load 0xA5 with `ready_in`=1.
  - `serial_out` = 1,0,1,0,0,1,0,1 on cycles N+1..N+8, `write_out`=1 throughout.
  - `done_out` pulses at N+9.
- **Stall:** load 0x3C; hold `ready_in`=0 for 3 cycles while bit 2 (1) is presented.
  - `serial_out` holds 1 and `write_out` stays 1 during the stall.
  - `done_out` arrives at N+12.
- **Load while busy:** load 0x0F, then pulse `load_in` with 0xF0 at N+3.
  - The link carries only 0x0F; `busy_out` stays 1 until `done_out`.
- **Back-to-back:** load 0x11, then load 0x22 in the `done_out` cycle.
  - The 0x22 MSB appears at the next cycle, giving a 9-cycle period.
- **Reset mid-frame:** assert `reset` after 4 bits of 0xFF.
  - All outputs are 0 on the next edge.
  - A subsequent load of 0x81 transfers cleanly.
- **Parity (`SERIALIZER_PARITY_EN`):**
  - 0x07 → ninth bit 1.
  - 0x03 → ninth bit 0.
  - `done_out` at N+10.
